// File: rtl/window_pkg.sv
// Shared constants, FSM state type, Hann coefficient table and Q0.8 rounding
// for the frame windowing block.
package window_pkg;

    localparam int SAMPLE_W = 8;
    localparam int LANES    = 8;
    localparam int COEF_W   = 8;
    localparam int OVR_W    = 8;
    localparam int LANE_W   = $clog2(LANES);
    localparam int PROD_W   = SAMPLE_W + COEF_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        HOLD
    } state_t;

    // Symmetric 8-point Hann window, Q0.8; lane 7 is the leftmost entry.
    localparam logic [LANES-1:0][COEF_W-1:0] COEF = {
        8'd0, 8'd48, 8'd156, 8'd243, 8'd243, 8'd156, 8'd48, 8'd0
    };

    // Round-half-up back to sample width; the product never exceeds 255*243,
    // so the result cannot overflow SAMPLE_W bits.
    function automatic logic [SAMPLE_W-1:0] round_q8(input logic [PROD_W-1:0] p);
        return SAMPLE_W'((p + PROD_W'(1 << (COEF_W - 1))) >> COEF_W);
    endfunction

endpackage

// File: rtl/window_coef_rom.sv
// Combinational lane-index to window-coefficient lookup.
module window_coef_rom
    import window_pkg::*;
(
    input  logic [LANE_W-1:0] lane,
    output logic [COEF_W-1:0] coef
);

    assign coef = COEF[lane];

endmodule

// File: rtl/window_apply.sv
// Applies an 8-point Hann window to packed sample frames, one lane per clock
// through a single multiplier, and hands the result downstream with valid/ready.
module window_apply
    import window_pkg::*;
(
    input  logic                         clk_50mhz,
    input  logic                         rst,
    input  logic [LANES*SAMPLE_W-1:0]    in_bus,
    input  logic                         in_set,
    output logic [LANES*SAMPLE_W-1:0]    win_bus,
    output logic                         win_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         overrun,
    output logic [OVR_W-1:0]             overrun_cnt
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t                            state, state_nx;
    logic [2:0]                        sync_pipe;
    logic                              fe;
    logic                              capture;
    logic                              ovr;
    logic [LANE_W-1:0]                 lane;
    logic [COEF_W-1:0]                 coef;
    logic [PROD_W-1:0]                 prod;
    logic [LANES-1:0][SAMPLE_W-1:0]    frame_buf;
    logic [LANES-1:0][SAMPLE_W-1:0]    win_q;

    // Two synchronizer stages, then a third flop purely for edge detection.
    assign fe      = sync_pipe[1] & ~sync_pipe[2];
    assign busy    = (state != IDLE);
    assign win_bus = win_q;

    window_coef_rom u_coef_rom (
        .lane (lane),
        .coef (coef)
    );

    assign prod = frame_buf[lane] * coef;

    always_ff @(posedge clk_50mhz) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        ovr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fe) begin
                    capture  = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                ovr = fe;
                if (lane == LAST_LANE) state_nx = HOLD;
            end
            HOLD: begin
                // A frame arriving on the handshake edge is taken, not dropped.
                if (win_valid && out_ready) begin
                    if (fe) begin
                        capture  = 1'b1;
                        state_nx = CALC;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    ovr = fe;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            sync_pipe   <= '0;
            frame_buf   <= '0;
            win_q       <= '0;
            win_valid   <= 1'b0;
            lane        <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            sync_pipe <= {sync_pipe[1:0], in_set};
            overrun   <= ovr;
            if (ovr && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;

            if (capture) begin
                frame_buf <= in_bus;
                lane      <= '0;
            end

            if (state == CALC) begin
                win_q[lane] <= round_q8(prod);
                if (lane == LAST_LANE) win_valid <= 1'b1;
                else                   lane      <= lane + 1'b1;
            end

            if (state == HOLD && win_valid && out_ready) win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_apply.sv
// Directed bench for window_apply: table of frames with hand-computed windowed
// results, plus sequences for hold, overrun, same-edge accept, level hold and reset.
module tb_window_apply;

    logic        clk;
    logic        rst;
    logic [63:0] in_bus;
    logic        in_set;
    logic [63:0] win_bus;
    logic        win_valid;
    logic        out_ready;
    logic        busy;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int checks   = 0;
    int failures = 0;
    int vld_rises  = 0;
    int ovr_cycles = 0;
    logic vld_prev = 1'b0;

    window_apply dut (
        .clk_50mhz   (clk),
        .rst         (rst),
        .in_bus      (in_bus),
        .in_set      (in_set),
        .win_bus     (win_bus),
        .win_valid   (win_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (win_valid && !vld_prev) vld_rises++;
        vld_prev = win_valid;
        if (overrun) ovr_cycles++;
    end

    typedef struct {
        logic [63:0] bus;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Counts negedges until win_valid is seen; returns 99 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (!win_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!win_valid) n = 99;
    endtask

    task automatic settle_low();
        in_set = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    int n;
    int r0, o0;
    logic [63:0] held;
    logic        stable;

    initial begin
        // lane i at bits [8i+7:8i]; expected = (x*c + 128) >> 8 per lane
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0030_9BF2_F29B_3000};
        vecs[1] = '{64'h8080_8080_8080_8080, 64'h0018_4E7A_7A4E_1800};
        vecs[2] = '{64'h8070_6050_4030_2010, 64'h0015_3B4C_3D1D_0600};
        vecs[3] = '{64'h0000_0002_0100_0500, 64'h0000_0002_0100_0100};
        vecs[4] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

        rst = 1'b1; in_bus = '0; in_set = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_win_bus", win_bus, 64'h0);
        chk("rst_flags", {60'h0, win_valid, busy, overrun, 1'b0}, 64'h0);
        chk("rst_ovr_cnt", {56'h0, overrun_cnt}, 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            in_bus = vecs[i].bus;
            in_set = 1'b1;
            wait_valid(n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'd11);
            chk($sformatf("v%0d_win_bus", i), win_bus, vecs[i].exp);
            @(negedge clk);
            chk($sformatf("v%0d_done", i), {62'h0, win_valid, busy}, 64'h0);
            settle_low();
        end

        // Hold with downstream stalled for 20 cycles.
        out_ready = 1'b0;
        in_bus = vecs[1].bus; in_set = 1'b1;
        wait_valid(n);
        in_set = 1'b0;
        held = win_bus; stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!win_valid || win_bus !== held || !busy) stable = 1'b0;
        end
        chk("hold_bus", held, vecs[1].exp);
        chk("hold_stable", {63'h0, stable}, 64'h1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", {62'h0, win_valid, busy}, 64'h0);
        settle_low();

        // Second frame event during CALC is dropped.
        o0 = ovr_cycles;
        in_bus = vecs[0].bus; in_set = 1'b1;
        repeat (4) @(negedge clk);
        in_set = 1'b0;
        repeat (2) @(negedge clk);
        in_bus = 64'h1111_1111_1111_1111; in_set = 1'b1;
        repeat (2) @(negedge clk);
        in_set = 1'b0;
        wait_valid(n);
        chk("calc_ovr_timeout", {63'h0, n != 99}, 64'h1);
        chk("calc_ovr_bus", win_bus, vecs[0].exp);
        chk("calc_ovr_pulses", 64'(ovr_cycles - o0), 64'd1);
        chk("calc_ovr_cnt", {56'h0, overrun_cnt}, 64'd1);
        settle_low();

        // 300 dropped frames while held saturate the counter.
        out_ready = 1'b0;
        in_bus = vecs[1].bus; in_set = 1'b1;
        wait_valid(n);
        settle_low();
        o0 = ovr_cycles;
        in_bus = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int k = 0; k < 300; k++) begin
            in_set = 1'b1;
            repeat (2) @(negedge clk);
            in_set = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("sat_cnt", {56'h0, overrun_cnt}, 64'd255);
        chk("sat_pulses", 64'(ovr_cycles - o0), 64'd300);
        chk("sat_bus_kept", win_bus, vecs[1].exp);
        chk("sat_valid_kept", {63'h0, win_valid}, 64'h1);

        // Handshake and new frame event on the same edge: accept, no overrun.
        o0 = ovr_cycles;
        in_bus = vecs[2].bus; in_set = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("same_edge_state", {62'h0, win_valid, busy}, 64'h1);
        wait_valid(n);
        chk("same_edge_latency", 64'(n), 64'd8);
        chk("same_edge_bus", win_bus, vecs[2].exp);
        chk("same_edge_no_ovr", 64'(ovr_cycles - o0), 64'd0);
        settle_low();

        // Level held high yields exactly one frame.
        r0 = vld_rises; o0 = ovr_cycles;
        in_bus = vecs[3].bus; in_set = 1'b1;
        repeat (10000) @(negedge clk);
        settle_low();
        chk("level_frames", 64'(vld_rises - r0), 64'd1);
        chk("level_no_ovr", 64'(ovr_cycles - o0), 64'd0);

        // Reset with lane 4 in progress discards the frame.
        r0 = vld_rises;
        in_bus = vecs[0].bus; in_set = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1; in_set = 1'b0;
        @(negedge clk);
        chk("midrst_bus", win_bus, 64'h0);
        chk("midrst_flags", {61'h0, win_valid, busy, overrun}, 64'h0);
        chk("midrst_cnt", {56'h0, overrun_cnt}, 64'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_frame", 64'(vld_rises - r0), 64'd0);
        in_bus = vecs[2].bus; in_set = 1'b1;
        wait_valid(n);
        chk("post_rst_latency", 64'(n), 64'd11);
        chk("post_rst_bus", win_bus, vecs[2].exp);
        settle_low();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
